gps_channel_wb_regs: RTL and testbench

- Wishbone B3 classic slave register bank for one GPS tracking channel; the responder end of the bus the team's wishbone master model drives.
- Holds the NCO frequency/offset words, acquisition threshold and config word, and drives them into the channel.
- Captures the six correlator accumulator results on each dump strobe and exposes them read-only, with a dump-ready/overrun status register.
- Sits inside gps_multichannel, one instance per channel, decoded by base address (0x0A00, 0x0B00, ...).

---
 rtl/gps_channel_wb_regs_pkg.sv | 39 +++
 rtl/gps_channel_wb_regs_if.sv | 24 ++
 rtl/gps_channel_wb_regs_wb_slave_if.sv | 46 ++++
 rtl/gps_channel_wb_regs.sv | 186 ++++++++++++++++++
 tb/tb_gps_channel_wb_regs.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_channel_wb_regs_pkg.sv
// Shared register-map constants for the GPS channel register bank.
// Also holds the byte-lane merge helper used by every writable register.
package gps_regs_pkg;

    localparam logic [7:0] OFF_CODE_FREQ  = 8'h00;
    localparam logic [7:0] OFF_CARR_FREQ  = 8'h04;
    localparam logic [7:0] OFF_CODE_OFF   = 8'h08;
    localparam logic [7:0] OFF_CARR_OFF   = 8'h0C;
    localparam logic [7:0] OFF_ACQ_THRESH = 8'h10;
    localparam logic [7:0] OFF_CONFIG     = 8'h14;
    localparam logic [7:0] OFF_PI         = 8'h18;
    localparam logic [7:0] OFF_PQ         = 8'h1C;
    localparam logic [7:0] OFF_LI         = 8'h20;
    localparam logic [7:0] OFF_LQ         = 8'h24;
    localparam logic [7:0] OFF_EI         = 8'h28;
    localparam logic [7:0] OFF_EQ         = 8'h2C;
    localparam logic [7:0] OFF_STATUS     = 8'h30;

    localparam int STAT_DUMP_READY = 0;
    localparam int STAT_OVERRUN    = 1;

    localparam int SVID_MSB = 31;
    localparam int SVID_LSB = 24;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gps_channel_wb_regs_if.sv
// Wishbone B3 classic bus bundle; signal names follow the slave's point of view.
interface gps_channel_wb_regs_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_stb_i;
    logic            wb_cyc_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gps_channel_wb_regs_wb_slave_if.sv
// Wishbone classic slave front end: page decode, single-cycle ack and byte write strobes.
// Shared with the multichannel status block.
module gps_wb_slave_if #(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h00000A00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cyc,
    input  logic            stb,
    input  logic            we,
    input  logic [AW-1:0]   adr,
    input  logic [DW/8-1:0] sel,
    output logic            ack_o,
    output logic            rd_o,
    output logic            wr_o,
    output logic [DW/8-1:0] wr_be_o,
    output logic [7:0]      off_o
);
    logic ack_r;
    logic req_s;
    logic unused_s;

    // Request decode; the outstanding ack blocks a new request so accesses pace every other cycle
    always_comb begin
        req_s    = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]) & ~ack_r;
        rd_o     = req_s & ~we;
        wr_o     = req_s & we;
        wr_be_o  = sel & {(DW/8){wr_o}};
        off_o    = {adr[7:2], 2'b00};
        unused_s = ^adr[1:0];
    end

    // Ack follows each accepted request by one edge and lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= req_s;
        end
    end

    assign ack_o = ack_r;

endmodule

// File: rtl/gps_channel_wb_regs.sv
// Per-channel register bank: NCO/threshold/config words out, correlator dump shadows in.
// The shadow read path uses next-state values so a read coinciding with a dump sees the new data.
module gps_channel_wb_regs
    import gps_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000A00,
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          ACC_W     = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    gps_channel_wb_regs_if.slave wb,
    input  logic                 dump_i,
    input  logic [ACC_W-1:0]     acc_pi_i,
    input  logic [ACC_W-1:0]     acc_pq_i,
    input  logic [ACC_W-1:0]     acc_li_i,
    input  logic [ACC_W-1:0]     acc_lq_i,
    input  logic [ACC_W-1:0]     acc_ei_i,
    input  logic [ACC_W-1:0]     acc_eq_i,
    output logic [31:0]          code_freq_o,
    output logic [31:0]          carr_freq_o,
    output logic [31:0]          code_off_o,
    output logic [31:0]          carr_off_o,
    output logic [31:0]          acq_thresh_o,
    output logic [31:0]          config_o,
    output logic                 freq_load_o,
    output logic                 dump_ready_o
);
    logic            rd_s;
    logic            wr_s;
    logic [DW/8-1:0] be_s;
    logic [7:0]      off_s;
    logic            ack_s;
    logic            clr_s;
    logic            freq_wr_s;
    logic [DW-1:0]   rd_data_s;

    logic [31:0]      rw_r       [6];
    logic [ACC_W-1:0] acc_s      [6];
    logic [ACC_W-1:0] shadow_r   [6];
    logic [ACC_W-1:0] shadow_nxt_s [6];
    logic             dump_ready_r;
    logic             overrun_r;
    logic             freq_pend_r;
    logic             freq_load_r;
    logic [DW-1:0]    dat_r;

    gps_wb_slave_if #(
        .AW        (AW),
        .DW        (DW),
        .BASE_ADDR (BASE_ADDR)
    ) u_slave (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .cyc     (wb.wb_cyc_i),
        .stb     (wb.wb_stb_i),
        .we      (wb.wb_we_i),
        .adr     (wb.wb_adr_i),
        .sel     (wb.wb_sel_i),
        .ack_o   (ack_s),
        .rd_o    (rd_s),
        .wr_o    (wr_s),
        .wr_be_o (be_s),
        .off_o   (off_s)
    );

    // Shadow next-state and write side-effect decode
    always_comb begin
        acc_s[0] = acc_pi_i;
        acc_s[1] = acc_pq_i;
        acc_s[2] = acc_li_i;
        acc_s[3] = acc_lq_i;
        acc_s[4] = acc_ei_i;
        acc_s[5] = acc_eq_i;
        for (int i = 0; i < 6; i++) begin
            if (dump_i) begin
                shadow_nxt_s[i] = acc_s[i];
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
        clr_s     = (off_s == OFF_STATUS) & be_s[0] & ~wb.wb_dat_i[0];
        freq_wr_s = wr_s & (off_s <= OFF_CARR_OFF);
    end

    // Read data mux; unmapped offsets return zero
    always_comb begin
        case (off_s)
            OFF_CODE_FREQ:  rd_data_s = rw_r[0];
            OFF_CARR_FREQ:  rd_data_s = rw_r[1];
            OFF_CODE_OFF:   rd_data_s = rw_r[2];
            OFF_CARR_OFF:   rd_data_s = rw_r[3];
            OFF_ACQ_THRESH: rd_data_s = rw_r[4];
            OFF_CONFIG:     rd_data_s = rw_r[5];
            OFF_PI:         rd_data_s = DW'(shadow_nxt_s[0]);
            OFF_PQ:         rd_data_s = DW'(shadow_nxt_s[1]);
            OFF_LI:         rd_data_s = DW'(shadow_nxt_s[2]);
            OFF_LQ:         rd_data_s = DW'(shadow_nxt_s[3]);
            OFF_EI:         rd_data_s = DW'(shadow_nxt_s[4]);
            OFF_EQ:         rd_data_s = DW'(shadow_nxt_s[5]);
            OFF_STATUS:     rd_data_s = {{(DW-2){1'b0}}, overrun_r, dump_ready_r};
            default:        rd_data_s = {DW{1'b0}};
        endcase
    end

    // Writable registers with per-byte-lane commit
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < 6; i++) begin
                rw_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_s && (off_s[7:2] == 6'(i))) begin
                    rw_r[i] <= merge_bytes(rw_r[i], wb.wb_dat_i, be_s);
                end else begin
                    rw_r[i] <= rw_r[i];
                end
            end
        end
    end

    // Correlator shadows load together on each dump
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= {ACC_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
            end
        end
    end

    // Status flags: a dump always wins over a simultaneous clear, leaving overrun untouched
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            dump_ready_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (dump_i) begin
            dump_ready_r <= 1'b1;
            if (!clr_s) begin
                overrun_r <= overrun_r | dump_ready_r;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (clr_s) begin
            dump_ready_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            dump_ready_r <= dump_ready_r;
            overrun_r    <= overrun_r;
        end
    end

    // Registered read data and the delayed frequency-load pulse
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            dat_r       <= {DW{1'b0}};
            freq_pend_r <= 1'b0;
            freq_load_r <= 1'b0;
        end else begin
            if (rd_s) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= {DW{1'b0}};
            end
            freq_pend_r <= freq_wr_s;
            freq_load_r <= freq_pend_r;
        end
    end

    assign wb.wb_ack_o  = ack_s;
    assign wb.wb_dat_o  = dat_r;
    assign code_freq_o  = rw_r[0];
    assign carr_freq_o  = rw_r[1];
    assign code_off_o   = rw_r[2];
    assign carr_off_o   = rw_r[3];
    assign acq_thresh_o = rw_r[4];
    assign config_o     = rw_r[5];
    assign freq_load_o  = freq_load_r;
    assign dump_ready_o = dump_ready_r;

endmodule

// File: tb/tb_gps_channel_wb_regs.sv
// Directed plus randomized bench for gps_channel_wb_regs against a register-map model.
module tb_gps_channel_wb_regs;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dump  = 1'b0;
    logic [31:0] acc [6];
    logic [31:0] code_freq, carr_freq, code_off, carr_off, acq_thresh, cfg;
    logic        freq_load, dump_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rw [6];
    logic [31:0] m_sh [6];
    logic        m_rdy, m_ovr;

    gps_channel_wb_regs_if bus ();

    gps_channel_wb_regs dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wb           (bus),
        .dump_i       (dump),
        .acc_pi_i     (acc[0]),
        .acc_pq_i     (acc[1]),
        .acc_li_i     (acc[2]),
        .acc_lq_i     (acc[3]),
        .acc_ei_i     (acc[4]),
        .acc_eq_i     (acc[5]),
        .code_freq_o  (code_freq),
        .carr_freq_o  (carr_freq),
        .code_off_o   (code_off),
        .carr_off_o   (carr_off),
        .acq_thresh_o (acq_thresh),
        .config_o     (cfg),
        .freq_load_o  (freq_load),
        .dump_ready_o (dump_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        if (off < 24) return m_rw[off / 4];
        else if (off < 48) return m_sh[(off - 24) / 4];
        else if (off == 48) return {30'd0, m_ovr, m_rdy};
        else return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_rw[i] = 32'd0;
            m_sh[i] = 32'd0;
        end
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_dump(input logic clr);
        for (int i = 0; i < 6; i++) m_sh[i] = acc[i];
        if (!clr && m_rdy) m_ovr = 1'b1;
        m_rdy = 1'b1;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] sel, input logic with_dump,
                        output logic acked, output logic [31:0] rd, output int lat,
                        output logic ack_next, output logic fl_at, output logic fl_next);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = wd;   bus.wb_sel_i = sel;
        dump = with_dump;
        acked = 1'b0; rd = 32'd0; lat = 0; fl_at = 1'b0;
        for (int i = 1; i <= 16 && !acked; i++) begin
            @(posedge clk); #1;
            dump = 1'b0;
            if (bus.wb_ack_o) begin
                acked = 1'b1; lat = i; rd = bus.wb_dat_o; fl_at = freq_load;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(posedge clk); #1;
        ack_next = bus.wb_ack_o;
        fl_next  = freq_load;
    endtask

    // In-page access checked against the model; returns the data read
    task automatic access(input logic we, input logic [7:0] off, input logic [31:0] wd,
                          input logic [3:0] sel, input logic with_dump, input string tag,
                          output logic [31:0] rd);
        logic acked, ack_next, fl_at, fl_next, clr;
        logic [31:0] exp;
        int lat, w;
        xfer(we, 32'h0000_0A00 | {24'd0, off}, wd, sel, with_dump, acked, rd, lat, ack_next, fl_at, fl_next);
        w = int'(off) & 32'hFC;
        clr = we && (w == 48) && sel[0] && !wd[0];
        if (with_dump) for (int i = 0; i < 6; i++) m_sh[i] = acc[i];
        exp = we ? 32'd0 : model_read(w);
        if (we && w < 24) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_rw[w / 4][8*b +: 8] = wd[8*b +: 8];
        end
        if (with_dump) begin
            if (!clr && m_rdy) m_ovr = 1'b1;
            m_rdy = 1'b1;
        end else if (clr) begin
            m_rdy = 1'b0; m_ovr = 1'b0;
        end
        check($sformatf("%s ack", tag), {31'd0, acked}, 32'd1);
        check($sformatf("%s ack_lat", tag), 32'(lat), 32'd1);
        check($sformatf("%s ack_width", tag), {31'd0, ack_next}, 32'd0);
        check($sformatf("%s dat", tag), rd, exp);
        check($sformatf("%s fl_at_ack", tag), {31'd0, fl_at}, 32'd0);
        check($sformatf("%s fl_next", tag), {31'd0, fl_next}, {31'd0, (we && w < 16)});
        check($sformatf("%s outs", tag),
              code_freq ^ {carr_freq[15:0], carr_freq[31:16]} ^ (code_off + 32'd3) ^ ~carr_off
              ^ {acq_thresh[7:0], acq_thresh[31:8]} ^ (cfg * 32'd5),
              m_rw[0] ^ {m_rw[1][15:0], m_rw[1][31:16]} ^ (m_rw[2] + 32'd3) ^ ~m_rw[3]
              ^ {m_rw[4][7:0], m_rw[4][31:8]} ^ (m_rw[5] * 32'd5));
        check($sformatf("%s dump_ready", tag), {31'd0, dump_ready}, {31'd0, m_rdy});
    endtask

    task automatic dump_pulse();
        @(posedge clk); #1; dump = 1'b1;
        @(posedge clk); #1; dump = 1'b0;
        model_dump(1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic acked, ack_next, fl_at, fl_next;
        int lat;
        logic [7:0] off;
        logic [1:0] low;

        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 32'd0; bus.wb_dat_i = 32'd0; bus.wb_sel_i = 4'd0;
        for (int i = 0; i < 6; i++) acc[i] = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("reset dat", bus.wb_dat_o, 32'd0);
        check("reset code_freq", code_freq, 32'd0);
        check("reset config", cfg, 32'd0);
        check("reset flags", {30'd0, freq_load, dump_ready}, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 8'h14, 32'd0, 4'hF, 1'b0, "rd_config_rst", rd);
        access(1'b0, 8'h30, 32'd0, 4'hF, 1'b0, "rd_status_rst", rd);

        access(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_carr_all", rd);
        access(1'b1, 8'h04, 32'h0FBC_2118, 4'b0011, 1'b0, "wr_carr_lo", rd);
        access(1'b0, 8'h04, 32'd0, 4'hF, 1'b0, "rd_carr", rd);
        check("carr_merge", rd, 32'hFFFF_2118);

        access(1'b1, 8'h14, 32'h1409_A1BE, 4'hF, 1'b0, "wr_config", rd);
        check("sv_id", {24'd0, cfg[31:24]}, 32'h0000_0014);
        access(1'b0, 8'h14, 32'd0, 4'hF, 1'b0, "rd_config", rd);
        check("config_rb", rd, 32'h1409_A1BE);

        for (int i = 0; i < 6; i++) acc[i] = $urandom;
        acc[0] = 32'h0000_0123; acc[5] = 32'hFFFF_FF00;
        dump_pulse();
        access(1'b0, 8'h30, 32'd0, 4'hF, 1'b0, "rd_status_1", rd);
        check("status_one", rd, 32'h1);
        access(1'b0, 8'h18, 32'd0, 4'hF, 1'b0, "rd_pi", rd);
        check("pi_value", rd, 32'h0000_0123);
        access(1'b0, 8'h2C, 32'd0, 4'hF, 1'b0, "rd_eq", rd);
        check("eq_value", rd, 32'hFFFF_FF00);
        access(1'b1, 8'h30, 32'h0, 4'hF, 1'b0, "wr_status_clr", rd);
        access(1'b0, 8'h30, 32'd0, 4'hF, 1'b0, "rd_status_clr", rd);
        check("status_clr", rd, 32'h0);

        for (int i = 0; i < 6; i++) acc[i] = $urandom;
        dump_pulse();
        for (int i = 0; i < 6; i++) acc[i] = $urandom;
        dump_pulse();
        access(1'b0, 8'h30, 32'd0, 4'hF, 1'b0, "rd_status_ovr", rd);
        check("status_ovr", rd, 32'h3);
        access(1'b0, 8'h24, 32'd0, 4'hF, 1'b0, "rd_lq_second", rd);
        check("lq_second", rd, acc[3]);
        for (int i = 0; i < 6; i++) acc[i] = $urandom;
        access(1'b1, 8'h30, 32'h0, 4'h1, 1'b1, "clr_with_dump", rd);
        access(1'b0, 8'h30, 32'd0, 4'hF, 1'b0, "rd_status_win", rd);
        check("dump_wins", rd, 32'h3);

        for (int i = 0; i < 6; i++) acc[i] = $urandom;
        access(1'b0, 8'h1C, 32'd0, 4'hF, 1'b1, "rd_pq_same_edge", rd);
        check("pq_same_edge", rd, acc[1]);

        xfer(1'b0, 32'h0000_0B00, 32'd0, 4'hF, 1'b0, acked, rd, lat, ack_next, fl_at, fl_next);
        check("other_page_noack", {31'd0, acked}, 32'd0);
        xfer(1'b1, 32'h0001_0A00, 32'hDEAD_BEEF, 4'hF, 1'b0, acked, rd, lat, ack_next, fl_at, fl_next);
        check("high_page_noack", {31'd0, acked}, 32'd0);
        check("high_page_nowrite", code_freq, m_rw[0]);
        access(1'b0, 8'h3C, 32'd0, 4'hF, 1'b0, "rd_unmapped", rd);
        access(1'b1, 8'h20, 32'h5555_AAAA, 4'hF, 1'b0, "wr_ro", rd);
        access(1'b0, 8'h20, 32'd0, 4'hF, 1'b0, "rd_ro_after_wr", rd);

        for (int n = 0; n < 60; n++) begin
            off = {$urandom_range(0, 15), 2'b00};
            low = 2'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < 6; i++) acc[i] = $urandom;
                    dump_pulse();
                end
                1: access(1'b0, off | {6'd0, low}, 32'd0, 4'hF, 1'b0, "rnd_rd", rd);
                2: access(1'b1, off | {6'd0, low}, $urandom, 4'($urandom), 1'b0, "rnd_wr", rd);
                default: begin
                    for (int i = 0; i < 6; i++) acc[i] = $urandom;
                    access(1'($urandom), off, $urandom, 4'($urandom), 1'b1, "rnd_dump_xfer", rd);
                end
            endcase
        end

        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 32'h0000_0A14; bus.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        check("pre_reset_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_ack_drop", {31'd0, bus.wb_ack_o}, 32'd0);
        check("async_dat_clear", bus.wb_dat_o, 32'd0);
        check("async_cfg_clear", cfg, 32'd0);
        check("async_status_clear", {31'd0, dump_ready}, 32'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
